// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration register set: writes from two round-robin arbitrated ports go to
// shadow registers and reach the active outputs only at a period boundary or on force_commit.
module pwm_cfg_scheduler #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_ADDR = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_valid,
  output logic              wr0_ready,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_valid,
  output logic              wr1_ready,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              pwm_period_end,
  input  logic              force_commit,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              pending,
  output logic              commit_done,
  output logic              addr_err
);

  localparam int unsigned NREG = MAX_ADDR + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic                         rr_last_q, rr_last_d;
  logic [NREG-1:0][DATA_W-1:0]  shadow_q, shadow_d;
  logic [NREG-1:0][DATA_W-1:0]  active_q, active_d;
  logic                         commit_done_q, commit_done_d;
  logic                         addr_err_q, addr_err_d;

  logic                         grant0, grant1, wr_fire, addr_ok;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;

  // rr_last names the port that won last; on contention the other port is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q != COMMIT) begin
      if (wr0_valid && (!wr1_valid || rr_last_q)) grant0 = 1'b1;
      else if (wr1_valid)                         grant1 = 1'b1;
    end
  end

  assign wr0_ready = grant0;
  assign wr1_ready = grant1;
  assign wr_fire   = grant0 | grant1;
  assign wr_addr   = grant1 ? wr1_addr : wr0_addr;
  assign wr_data   = grant1 ? wr1_data : wr0_data;
  assign addr_ok   = (wr_addr <= ADDR_W'(MAX_ADDR));

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    commit_done_d = 1'b0;
    addr_err_d    = wr_fire && !addr_ok;

    if (wr_fire) rr_last_d = grant1;

    for (int unsigned i = 0; i < NREG; i++) begin
      if (wr_fire && addr_ok && (wr_addr == ADDR_W'(i))) shadow_d[i] = wr_data;
    end

    unique case (state_q)
      IDLE: begin
        if (wr_fire && addr_ok) state_d = PENDING;
      end
      PENDING: begin
        if (pwm_period_end || force_commit) state_d = COMMIT;
      end
      COMMIT: begin
        // Shadow is sampled at exit so a write landing with the boundary is included.
        active_d      = shadow_q;
        commit_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_last_q     <= 1'b1;
      shadow_q      <= '0;
      active_q      <= '0;
      commit_done_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      commit_done_q <= commit_done_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign en_reg_out_7_0  = active_q[0];
  assign en_reg_out_15_8 = active_q[1];
  assign en_reg_pwm_7_0  = active_q[2];
  assign en_reg_pwm_15_8 = active_q[3];
  assign pwm_duty_cycle  = active_q[4];
  assign pending         = (state_q != IDLE);
  assign commit_done     = commit_done_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: a shadow/active register model queues the expected
// snapshot at each commit request and compares it when commit_done fires.
module tb_pwm_cfg_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [6:0] wr0_addr, wr1_addr;
  logic [7:0] wr0_data, wr1_data;
  logic       pwm_period_end, force_commit;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       pending, commit_done, addr_err;

  always #5 clk = ~clk;

  pwm_cfg_scheduler #(.ADDR_W(7), .DATA_W(8), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst),
    .wr0_valid(wr0_valid), .wr0_ready(wr0_ready), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_valid(wr1_valid), .wr1_ready(wr1_ready), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .pwm_period_end(pwm_period_end), .force_commit(force_commit),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .pending(pending), .commit_done(commit_done), .addr_err(addr_err)
  );

  typedef logic [4:0][7:0] regs_t;

  regs_t mshadow, mactive, exp_r;
  logic  mrr;
  regs_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    seen;

  function automatic regs_t dut_act();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic void set_reg(input int a, input logic [7:0] d);
    for (int i = 0; i < 5; i++) if (a == i) mshadow[i] = d;
  endfunction

  task automatic clear_inputs();
    wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
    pwm_period_end = 1'b0; force_commit = 1'b0;
  endtask

  // Single write on one port; returns at the negedge following the accepting edge.
  task automatic wr(input int port, input logic [6:0] addr, input logic [7:0] data);
    bit done = 1'b0;
    @(negedge clk);
    if (port == 0) begin wr0_valid = 1'b1; wr0_addr = addr; wr0_data = data; end
    else           begin wr1_valid = 1'b1; wr1_addr = addr; wr1_data = data; end
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      if ((port == 0 && wr0_ready) || (port == 1 && wr1_ready)) done = 1'b1;
      @(posedge clk);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL wr_grant port%0d got no ready required ready within 10 cycles", port);
    end else begin
      if (addr <= 7'd4) set_reg(int'(addr), data);
      mrr = (port == 1);
    end
    @(negedge clk);
    if (port == 0) wr0_valid = 1'b0; else wr1_valid = 1'b0;
  endtask

  task automatic pulse(input bit pe, input bit fc);
    @(negedge clk);
    pwm_period_end = pe; force_commit = fc;
    @(negedge clk);
    pwm_period_end = 1'b0; force_commit = 1'b0;
  endtask

  task automatic wait_commit(output bit s);
    s = 1'b0;
    for (int c = 0; c < 6 && !s; c++) begin
      @(negedge clk);
      if (commit_done) s = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    vectors++;
    if (dut_act() !== '0) begin
      miscompares++; $display("FAIL reset_regs got %h required %h", dut_act(), 40'h0);
    end
    vectors++;
    if ({pending, commit_done, addr_err} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b required 000", {pending, commit_done, addr_err});
    end
    rst = 1'b0;
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL reset_first_grant got %b required 10", {wr0_ready, wr1_ready});
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    mshadow = '0; mactive = '0; mrr = 1'b1;
  endtask

  task automatic test_deferred();
    wr(0, 7'd4, 8'h80);
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (pwm_duty_cycle !== 8'h00 || pending !== 1'b1) begin
        miscompares++;
        $display("FAIL deferred_hold got duty=%h pending=%b required duty=00 pending=1", pwm_duty_cycle, pending);
      end
    end
    exp_q.push_back(mshadow);
    pulse(1'b1, 1'b0);
    vectors++;
    if (pwm_duty_cycle !== 8'h00 || commit_done !== 1'b0) begin
      miscompares++;
      $display("FAIL deferred_latency got duty=%h done=%b required duty=00 done=0", pwm_duty_cycle, commit_done);
    end
    wait_commit(seen);
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL deferred_commit got no commit_done required pulse");
    end
    exp_r = exp_q.pop_front();
    vectors++;
    if (dut_act() !== exp_r) begin
      miscompares++; $display("FAIL deferred_regs got %h required %h", dut_act(), exp_r);
    end
    mactive = exp_r;
    @(negedge clk);
    vectors++;
    if (commit_done !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL deferred_pulse_width got done=%b pending=%b required 0 0", commit_done, pending);
    end
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    logic [1:0] expg;
    for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
      @(negedge clk);
      wr0_valid = (i0 < 4); wr0_addr = 7'(i0); wr0_data = 8'h10 + 8'(i0);
      wr1_valid = (i1 < 4); wr1_addr = 7'(i1); wr1_data = 8'h20 + 8'(i1);
      #1;
      if (wr0_valid && wr1_valid) expg = mrr ? 2'b10 : 2'b01;
      else if (wr0_valid)         expg = 2'b10;
      else                        expg = 2'b01;
      vectors++;
      if ({wr0_ready, wr1_ready} !== expg) begin
        miscompares++;
        $display("FAIL contention_grant cycle %0d got %b required %b", c, {wr0_ready, wr1_ready}, expg);
      end
      if (expg[1]) begin set_reg(i0, wr0_data); i0++; mrr = 1'b0; end
      else         begin set_reg(i1, wr1_data); i1++; mrr = 1'b1; end
    end
    @(negedge clk);
    wr0_valid = 1'b0; wr1_valid = 1'b0;
    exp_q.push_back(mshadow);
    pulse(1'b1, 1'b0);
    wait_commit(seen);
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL contention_commit got no commit_done required pulse");
    end
    exp_r = exp_q.pop_front();
    vectors++;
    if (dut_act() !== exp_r) begin
      miscompares++; $display("FAIL contention_regs got %h required %h", dut_act(), exp_r);
    end
    mactive = exp_r;
  endtask

  task automatic test_bad_addr();
    wr(1, 7'd5, 8'hFF);
    vectors++;
    if (addr_err !== 1'b1 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_addr_flag got err=%b pending=%b required err=1 pending=0", addr_err, pending);
    end
    @(negedge clk);
    vectors++;
    if (addr_err !== 1'b0) begin
      miscompares++; $display("FAIL bad_addr_pulse got %b required 0", addr_err);
    end
    pulse(1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (commit_done !== 1'b0 || dut_act() !== mactive) begin
        miscompares++;
        $display("FAIL bad_addr_nochange got done=%b regs=%h required done=0 regs=%h", commit_done, dut_act(), mactive);
      end
    end
  endtask

  task automatic test_boundary_race();
    wr(0, 7'd0, 8'h11);
    @(negedge clk);
    wr0_valid = 1'b1; wr0_addr = 7'd2; wr0_data = 8'h3C;
    pwm_period_end = 1'b1;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL race_grant got %b required 10", {wr0_ready, wr1_ready});
    end
    set_reg(2, 8'h3C); mrr = 1'b0;
    exp_q.push_back(mshadow);
    @(negedge clk);
    pwm_period_end = 1'b0;
    wr0_addr = 7'd3; wr0_data = 8'h5A;
    wr1_valid = 1'b1; wr1_addr = 7'd1; wr1_data = 8'h77;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready, pending, commit_done} !== 4'b0010) begin
      miscompares++;
      $display("FAIL race_commit_cycle got rdy/pend/done=%b required 0010", {wr0_ready, wr1_ready, pending, commit_done});
    end
    @(negedge clk);
    vectors++;
    if (commit_done !== 1'b1) begin
      miscompares++; $display("FAIL race_commit_done got %b required 1", commit_done);
    end
    exp_r = exp_q.pop_front();
    vectors++;
    if (dut_act() !== exp_r) begin
      miscompares++; $display("FAIL race_regs got %h required %h", dut_act(), exp_r);
    end
    mactive = exp_r;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL race_held_grant1 got %b required 01", {wr0_ready, wr1_ready});
    end
    set_reg(1, 8'h77); mrr = 1'b1;
    @(negedge clk);
    wr1_valid = 1'b0;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL race_held_grant0 got %b required 10", {wr0_ready, wr1_ready});
    end
    set_reg(3, 8'h5A); mrr = 1'b0;
    @(negedge clk);
    wr0_valid = 1'b0;
    exp_q.push_back(mshadow);
    pulse(1'b1, 1'b1);
    wait_commit(seen);
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL dual_commit got no commit_done required pulse");
    end
    exp_r = exp_q.pop_front();
    vectors++;
    if (dut_act() !== exp_r) begin
      miscompares++; $display("FAIL dual_regs got %h required %h", dut_act(), exp_r);
    end
    mactive = exp_r;
    @(negedge clk);
    vectors++;
    if (commit_done !== 1'b0 || pending !== 1'b0) begin
      miscompares++;
      $display("FAIL dual_single got done=%b pending=%b required 0 0", commit_done, pending);
    end
  endtask

  task automatic test_idle_race();
    @(negedge clk);
    wr0_valid = 1'b1; wr0_addr = 7'd4; wr0_data = 8'h42;
    pwm_period_end = 1'b1;
    #1;
    vectors++;
    if (wr0_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_race_grant got %b required 1", wr0_ready);
    end
    set_reg(4, 8'h42); mrr = 1'b0;
    @(negedge clk);
    wr0_valid = 1'b0; pwm_period_end = 1'b0;
    vectors++;
    if (pending !== 1'b1) begin
      miscompares++; $display("FAIL idle_race_pending got %b required 1", pending);
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (commit_done !== 1'b0 || pwm_duty_cycle !== mactive[4]) begin
        miscompares++;
        $display("FAIL idle_race_missed got done=%b duty=%h required done=0 duty=%h", commit_done, pwm_duty_cycle, mactive[4]);
      end
    end
    exp_q.push_back(mshadow);
    pulse(1'b0, 1'b1);
    wait_commit(seen);
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL force_commit got no commit_done required pulse");
    end
    exp_r = exp_q.pop_front();
    vectors++;
    if (dut_act() !== exp_r) begin
      miscompares++; $display("FAIL force_regs got %h required %h", dut_act(), exp_r);
    end
    mactive = exp_r;
  endtask

  task automatic test_reset_mid_commit();
    wr(0, 7'd1, 8'h99);
    pulse(1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mshadow = '0; mactive = '0; mrr = 1'b1;
    vectors++;
    if (dut_act() !== '0 || {pending, commit_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL midcommit_reset got regs=%h pend/done=%b required regs=0 00", dut_act(), {pending, commit_done});
    end
    @(negedge clk);
    vectors++;
    if (commit_done !== 1'b0 || dut_act() !== '0) begin
      miscompares++;
      $display("FAIL midcommit_nodone got done=%b regs=%h required done=0 regs=0", commit_done, dut_act());
    end
    wr0_valid = 1'b1; wr1_valid = 1'b1;
    #1;
    vectors++;
    if ({wr0_ready, wr1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL midcommit_rr got %b required 10", {wr0_ready, wr1_ready});
    end
    wr0_valid = 1'b0; wr1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_deferred();
    test_contention();
    test_bad_addr();
    test_boundary_race();
    test_idle_race();
    test_reset_mid_commit();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
